// File: rtl/apple_spawn_ctrl_if.sv
// rtl/apple_spawn_ctrl_if.sv - generator step and occupancy-check handshake between the spawn sequencer and its helpers
interface apple_spawn_ctrl_if;
  logic       update;
  logic [9:0] rand_X;
  logic [8:0] rand_Y;
  logic       chk_req;
  logic [9:0] chk_X;
  logic [8:0] chk_Y;
  logic       chk_ack;
  logic       chk_hit;

  modport master (
    output update, chk_req, chk_X, chk_Y,
    input  rand_X, rand_Y, chk_ack, chk_hit
  );

  modport slave (
    input  update, chk_req, chk_X, chk_Y,
    output rand_X, rand_Y, chk_ack, chk_hit
  );
endinterface

// File: rtl/apple_spawn_ctrl.sv
// rtl/apple_spawn_ctrl.sv - apple respawn sequencer: step generator, settle, sample, occupancy check, retry or fallback
module apple_spawn_ctrl #(
  parameter int MAX_TRIES  = 8,
  parameter int SETTLE     = 2,
  parameter int INIT_X     = 70,
  parameter int INIT_Y     = 90,
  parameter int FALLBACK_X = 40,
  parameter int FALLBACK_Y = 40,
  parameter int X_MIN      = 40,
  parameter int X_MAX      = 569,
  parameter int Y_MIN      = 40,
  parameter int Y_MAX      = 399
) (
  input  logic                VGA_clk,
  input  logic                rst_n,
  input  logic                eat,
  apple_spawn_ctrl_if.master  bus,
  output logic [9:0]          apple_X,
  output logic [8:0]          apple_Y,
  output logic                apple_valid,
  output logic                busy,
  output logic [7:0]          eaten
);

  typedef enum logic [2:0] {SHOW, REQ, WAIT, SAMPLE, CHECK, COMMIT} state_t;

  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] X_HI   = 10'(X_MAX);
  localparam logic [8:0] Y_LO   = 9'(Y_MIN);
  localparam logic [8:0] Y_HI   = 9'(Y_MAX);
  localparam logic [9:0] X_INIT = 10'(INIT_X);
  localparam logic [8:0] Y_INIT = 9'(INIT_Y);
  localparam logic [9:0] X_FB   = 10'(FALLBACK_X);
  localparam logic [8:0] Y_FB   = 9'(FALLBACK_Y);
  localparam logic [3:0] TRIES  = 4'(MAX_TRIES);
  localparam logic [2:0] SETTLE_W = 3'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] settle_q, settle_d;
  logic [3:0] try_q, try_d;
  logic       fb_q, fb_d;
  logic       update_q, update_d;
  logic       chk_req_q, chk_req_d;
  logic [9:0] chk_x_q, chk_x_d;
  logic [8:0] chk_y_q, chk_y_d;
  logic [9:0] apple_x_d;
  logic [8:0] apple_y_d;
  logic       apple_valid_d, busy_d;
  logic [7:0] eaten_d;

  logic       in_range, exhausted, fail_try;
  logic [3:0] try_inc;

  assign in_range  = (bus.rand_X >= X_LO) && (bus.rand_X <= X_HI) &&
                     (bus.rand_Y >= Y_LO) && (bus.rand_Y <= Y_HI);
  assign try_inc   = try_q + 4'd1;
  assign exhausted = (try_inc == TRIES);
  assign fail_try  = ((state_q == SAMPLE) && !in_range) ||
                     ((state_q == CHECK) && bus.chk_ack && bus.chk_hit);

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) state_q <= SHOW;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW:    if (eat) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (settle_q == SETTLE_W) state_d = SAMPLE;
      SAMPLE:  state_d = in_range ? CHECK : (exhausted ? COMMIT : REQ);
      CHECK:   if (bus.chk_ack)
                 state_d = (!bus.chk_hit || exhausted) ? COMMIT : REQ;
      COMMIT:  state_d = SHOW;
      default: state_d = SHOW;
    endcase
  end

  // Every output is the registered image of this decode, so busy tracks the state exactly.
  always_comb begin
    settle_d      = (state_q == WAIT) ? settle_q + 3'd1 : 3'd0;
    try_d         = try_q;
    fb_d          = fb_q;
    update_d      = (state_q == REQ);
    chk_req_d     = ((state_q == SAMPLE) && in_range) ||
                    ((state_q == CHECK) && !bus.chk_ack);
    chk_x_d       = chk_x_q;
    chk_y_d       = chk_y_q;
    apple_x_d     = apple_X;
    apple_y_d     = apple_Y;
    apple_valid_d = 1'b0;
    busy_d        = (state_d != SHOW);
    eaten_d       = eaten;
    case (state_q)
      SHOW: begin
        apple_valid_d = !eat;
        if (eat) begin
          try_d = 4'd0;
          fb_d  = 1'b0;
          if (eaten != 8'hFF) eaten_d = eaten + 8'd1;
        end
      end
      SAMPLE: begin
        chk_x_d = bus.rand_X;
        chk_y_d = bus.rand_Y;
      end
      COMMIT: begin
        apple_valid_d = 1'b1;
        apple_x_d     = fb_q ? X_FB : chk_x_q;
        apple_y_d     = fb_q ? Y_FB : chk_y_q;
      end
      default: ;
    endcase
    if (fail_try) begin
      try_d = try_inc;
      if (exhausted) fb_d = 1'b1;
    end
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q    <= 3'd0;
      try_q       <= 4'd0;
      fb_q        <= 1'b0;
      update_q    <= 1'b0;
      chk_req_q   <= 1'b0;
      chk_x_q     <= 10'd0;
      chk_y_q     <= 9'd0;
      apple_X     <= X_INIT;
      apple_Y     <= Y_INIT;
      apple_valid <= 1'b1;
      busy        <= 1'b0;
      eaten       <= 8'd0;
    end else begin
      settle_q    <= settle_d;
      try_q       <= try_d;
      fb_q        <= fb_d;
      update_q    <= update_d;
      chk_req_q   <= chk_req_d;
      chk_x_q     <= chk_x_d;
      chk_y_q     <= chk_y_d;
      apple_X     <= apple_x_d;
      apple_Y     <= apple_y_d;
      apple_valid <= apple_valid_d;
      busy        <= busy_d;
      eaten       <= eaten_d;
    end
  end

  assign bus.update  = update_q;
  assign bus.chk_req = chk_req_q;
  assign bus.chk_X   = chk_x_q;
  assign bus.chk_Y   = chk_y_q;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// tb/tb_apple_spawn_ctrl.sv - directed bench for the apple respawn sequencer
module tb_apple_spawn_ctrl;
  logic       VGA_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       eat     = 1'b0;
  logic [9:0] apple_X;
  logic [8:0] apple_Y;
  logic       apple_valid, busy;
  logic [7:0] eaten;

  apple_spawn_ctrl_if bus();

  apple_spawn_ctrl dut (
    .VGA_clk(VGA_clk), .rst_n(rst_n), .eat(eat), .bus(bus),
    .apple_X(apple_X), .apple_Y(apple_Y), .apple_valid(apple_valid),
    .busy(busy), .eaten(eaten)
  );

  always #5 VGA_clk = ~VGA_clk;

  int tests = 0;
  int fails = 0;

  int cand_x [16];
  int cand_y [16];

  // results of the last respawn run
  bit r_done, r_valid_at1;
  int r_cyc, r_upd, r_req_starts, r_unstable, r_first_upd, r_first_req;
  int r_hx, r_hy;

  task automatic set_cands(input int x, input int y);
    for (int i = 0; i < 16; i++) begin
      cand_x[i] = x;
      cand_y[i] = y;
    end
  endtask

  // Pulse eat once and play generator + checker until the apple is drawn again.
  task automatic respawn(input int ack_delay, input int hits, input bit spam);
    int rc, nchk;
    rc = 0; nchk = 0;
    r_done = 0; r_cyc = 0; r_upd = 0; r_req_starts = 0; r_unstable = 0;
    r_first_upd = -1; r_first_req = -1; r_hx = -1; r_hy = -1; r_valid_at1 = 1;
    @(negedge VGA_clk);
    eat = 1'b1;
    while (!r_done && r_cyc < 500) begin
      @(negedge VGA_clk);
      r_cyc++;
      eat = 1'b0; bus.chk_ack = 1'b0; bus.chk_hit = 1'b0;
      if (r_cyc == 1) r_valid_at1 = apple_valid;
      if (bus.update) begin
        if (r_first_upd < 0) r_first_upd = r_cyc;
        if (r_upd < 16) begin
          bus.rand_X = 10'(cand_x[r_upd]);
          bus.rand_Y = 9'(cand_y[r_upd]);
        end
        r_upd++;
      end
      if (bus.chk_req) begin
        if (rc == 0) begin
          r_req_starts++;
          r_hx = int'(bus.chk_X);
          r_hy = int'(bus.chk_Y);
          if (r_first_req < 0) r_first_req = r_cyc;
        end else if (int'(bus.chk_X) != r_hx || int'(bus.chk_Y) != r_hy) begin
          r_unstable++;
        end
        if (rc == ack_delay) begin
          bus.chk_ack = 1'b1;
          bus.chk_hit = (nchk < hits);
          nchk++;
          rc = 0;
        end else begin
          rc++;
        end
      end else begin
        rc = 0;
      end
      if (apple_valid && r_cyc > 1) r_done = 1;
      else if (spam && busy) eat = 1'b1;
    end
    eat = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge VGA_clk);
      eat = 1'($urandom); bus.chk_ack = 1'($urandom); bus.chk_hit = 1'($urandom);
      bus.rand_X = 10'($urandom); bus.rand_Y = 9'($urandom);
    end
    tests++; if (apple_X !== 10'd70) begin fails++; $display("FAIL reset_apple_X got %0d expected 70", apple_X); end
    tests++; if (apple_Y !== 9'd90) begin fails++; $display("FAIL reset_apple_Y got %0d expected 90", apple_Y); end
    tests++; if (apple_valid !== 1'b1) begin fails++; $display("FAIL reset_valid got %b expected 1", apple_valid); end
    tests++; if (eaten !== 8'd0) begin fails++; $display("FAIL reset_eaten got %0d expected 0", eaten); end
    tests++; if (bus.update !== 1'b0) begin fails++; $display("FAIL reset_update got %b expected 0", bus.update); end
    tests++; if (bus.chk_req !== 1'b0) begin fails++; $display("FAIL reset_chk_req got %b expected 0", bus.chk_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
    @(negedge VGA_clk);
    eat = 1'b0; bus.chk_ack = 1'b0; bus.chk_hit = 1'b0;
    rst_n = 1'b1;
    @(negedge VGA_clk);
  endtask

  task automatic test_single_respawn;
    set_cands(130, 110);
    respawn(3, 0, 0);
    tests++; if (!r_done) begin fails++; $display("FAIL single_timeout got %0d cycles expected completion", r_cyc); end
    tests++; if (r_upd != 1) begin fails++; $display("FAIL single_updates got %0d expected 1", r_upd); end
    tests++; if (r_hx != 130 || r_hy != 110) begin fails++; $display("FAIL single_chk_xy got %0d,%0d expected 130,110", r_hx, r_hy); end
    tests++; if (r_unstable != 0) begin fails++; $display("FAIL single_chk_stable got %0d changes expected 0", r_unstable); end
    tests++; if (r_valid_at1 !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %b expected 0", r_valid_at1); end
    tests++; if (r_cyc != 11) begin fails++; $display("FAIL single_latency got %0d expected 11", r_cyc); end
    tests++; if (apple_X !== 10'd130 || apple_Y !== 9'd110) begin fails++; $display("FAIL single_apple got %0d,%0d expected 130,110", apple_X, apple_Y); end
    tests++; if (eaten !== 8'd1) begin fails++; $display("FAIL single_eaten got %0d expected 1", eaten); end
  endtask

  task automatic test_min_latency;
    set_cands(200, 300);
    respawn(0, 0, 0);
    tests++; if (r_first_upd != 2) begin fails++; $display("FAIL lat_update_cycle got %0d expected 2", r_first_upd); end
    tests++; if (r_first_req != 6) begin fails++; $display("FAIL lat_chk_req_cycle got %0d expected 6", r_first_req); end
    tests++; if (r_cyc != 8) begin fails++; $display("FAIL lat_valid_cycle got %0d expected 8", r_cyc); end
    tests++; if (apple_X !== 10'd200 || apple_Y !== 9'd300) begin fails++; $display("FAIL lat_apple got %0d,%0d expected 200,300", apple_X, apple_Y); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL lat_busy got %b expected 0", busy); end
  endtask

  task automatic test_hit_retry;
    set_cands(130, 110);
    cand_y[1] = 130; cand_y[2] = 150;
    respawn(1, 2, 0);
    tests++; if (r_upd != 3) begin fails++; $display("FAIL retry_updates got %0d expected 3", r_upd); end
    tests++; if (apple_X !== 10'd130 || apple_Y !== 9'd150) begin fails++; $display("FAIL retry_apple got %0d,%0d expected 130,150", apple_X, apple_Y); end
    tests++; if (eaten !== 8'd3) begin fails++; $display("FAIL retry_eaten got %0d expected 3", eaten); end
  endtask

  task automatic test_exhaustion;
    set_cands(300, 200);
    respawn(0, 99, 0);
    tests++; if (r_upd != 8) begin fails++; $display("FAIL exhaust_updates got %0d expected 8", r_upd); end
    tests++; if (r_req_starts != 8) begin fails++; $display("FAIL exhaust_queries got %0d expected 8", r_req_starts); end
    tests++; if (apple_X !== 10'd40 || apple_Y !== 9'd40) begin fails++; $display("FAIL exhaust_apple got %0d,%0d expected 40,40", apple_X, apple_Y); end
    tests++; if (apple_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL exhaust_show got valid=%b busy=%b expected 1,0", apple_valid, busy); end
  endtask

  task automatic test_range_ignore;
    set_cands(250, 200);
    cand_x[0] = 600;
    respawn(0, 0, 1);
    tests++; if (r_upd != 2) begin fails++; $display("FAIL range_updates got %0d expected 2", r_upd); end
    tests++; if (r_req_starts != 1) begin fails++; $display("FAIL range_queries got %0d expected 1", r_req_starts); end
    tests++; if (apple_X !== 10'd250 || apple_Y !== 9'd200) begin fails++; $display("FAIL range_apple got %0d,%0d expected 250,200", apple_X, apple_Y); end
    tests++; if (eaten !== 8'd5) begin fails++; $display("FAIL busy_eat_ignored got %0d expected 5", eaten); end
  endtask

  task automatic test_reset_mid_check;
    int n, bad;
    set_cands(300, 300);
    @(negedge VGA_clk);
    eat = 1'b1;
    @(negedge VGA_clk);
    eat = 1'b0;
    n = 0;
    while (!bus.chk_req && n < 50) begin
      @(negedge VGA_clk);
      if (bus.update) begin bus.rand_X = 10'd300; bus.rand_Y = 9'd300; end
      n++;
    end
    tests++; if (bus.chk_req !== 1'b1) begin fails++; $display("FAIL midrst_reach_check got %b expected 1", bus.chk_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.chk_req !== 1'b0) begin fails++; $display("FAIL midrst_chk_req_async got %b expected 0", bus.chk_req); end
    tests++; if (apple_X !== 10'd70 || apple_Y !== 9'd90 || apple_valid !== 1'b1) begin fails++; $display("FAIL midrst_apple got %0d,%0d,%b expected 70,90,1", apple_X, apple_Y, apple_valid); end
    tests++; if (eaten !== 8'd0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_counters got eaten=%0d busy=%b expected 0,0", eaten, busy); end
    bad = 0;
    repeat (4) begin
      @(negedge VGA_clk);
      bus.chk_ack = 1'b1; eat = 1'b1;
      if (bus.update || bus.chk_req) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrst_quiet got %0d pulses expected 0", bad); end
    bus.chk_ack = 1'b0; eat = 1'b0;
    rst_n = 1'b1;
    @(negedge VGA_clk);
  endtask

  task automatic test_saturation;
    int incomplete;
    incomplete = 0;
    set_cands(100, 100);
    for (int i = 0; i < 255; i++) begin
      respawn(0, 0, 0);
      if (!r_done) incomplete++;
    end
    tests++; if (incomplete != 0) begin fails++; $display("FAIL sat_timeouts got %0d expected 0", incomplete); end
    tests++; if (eaten !== 8'd255) begin fails++; $display("FAIL sat_255 got %0d expected 255", eaten); end
    respawn(0, 0, 0);
    tests++; if (eaten !== 8'd255) begin fails++; $display("FAIL sat_hold got %0d expected 255", eaten); end
  endtask

  initial begin
    bus.rand_X = 10'd0; bus.rand_Y = 9'd0; bus.chk_ack = 1'b0; bus.chk_hit = 1'b0;
    test_reset();
    test_single_respawn();
    test_min_latency();
    test_hit_retry();
    test_exhaustion();
    test_range_ignore();
    test_reset_mid_check();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apple_spawn_ctrl.md
# apple_spawn_ctrl

Sequencer that owns apple placement for the snake game. On each eat event it steps the pseudo-random apple position generator, samples the candidate coordinate, and asks the body-occupancy checker whether the snake covers that cell. It retries on a hit and commits a fallback position once the retry budget is spent. It sits between the snake collision logic, the position generator and the VGA draw logic, which renders the apple only while `apple_valid` is high.

## Interface
- `MAX_TRIES`, 8: candidate samples per respawn before fallback (1..15).
- `SETTLE`, 2: cycles waited after an `update` pulse before sampling `rand_X`/`rand_Y` (1..7).
- `INIT_X`, 70: apple X after reset.
- `INIT_Y`, 90: apple Y after reset.
- `FALLBACK_X`, 40: X committed when tries are exhausted.
- `FALLBACK_Y`, 40: Y committed when tries are exhausted.
- `X_MIN`/`X_MAX`, 40/569: legal X range, inclusive.
- `Y_MIN`/`Y_MAX`, 40/399: legal Y range, inclusive.

Ports:
- `VGA_clk` in 1: sole clock, all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `eat` in 1: one-cycle pulse, snake head overlaps the apple.
- `rand_X` in 10: generator X, free-running.
- `rand_Y` in 9: generator Y, advances on `update`.
- `update` out 1: one-cycle pulse stepping the generator Y.
- `chk_req` out 1: occupancy query valid.
- `chk_X` out 10 / `chk_Y` out 9: query coordinate.
- `chk_ack` in 1: checker response valid. One cycle; only meaningful while `chk_req` is high.
- `chk_hit` in 1: with `chk_ack`, 1 = the snake occupies the cell.
- `apple_X` out 10 / `apple_Y` out 9: committed apple position.
- `apple_valid` out 1: apple is drawn and collidable.
- `busy` out 1: respawn in progress (any state other than SHOW).
- `eaten` out 8: apples eaten, saturates at 255.

## Operation
- **Reset values:** state SHOW; `apple_X`=INIT_X; `apple_Y`=INIT_Y; `apple_valid`=1; `update`=0; `chk_req`=0; `chk_X`/`chk_Y`=0; `busy`=0; `eaten`=0; try counter=0.
- All outputs are registered.
- **SHOW:** `apple_valid`=1. On `eat`:
  - `eaten` += 1, saturating at 255.
  - `apple_valid` falls on the next edge.
  - try counter clears.
  - Next state REQ.
- **REQ:** `update`=1 for exactly one cycle. Next state WAIT.
- **WAIT:** count SETTLE cycles, then go to SAMPLE.
- **SAMPLE:** latch `rand_X`/`rand_Y` into `chk_X`/`chk_Y`.
  - If the candidate is outside [X_MIN..X_MAX] x [Y_MIN..Y_MAX], it is a failed try (see try rule).
  - Otherwise go to CHECK.
- **CHECK:** `chk_req`=1, with `chk_X`/`chk_Y` held stable until `chk_ack`. On `chk_ack`, `chk_req` drops on the next edge, then:
  - `chk_hit`=0: go to COMMIT with the candidate.
  - `chk_hit`=1: failed try.
- **Try rule:** a failed try increments the try counter.
  - If the new count equals MAX_TRIES, go to COMMIT with (FALLBACK_X, FALLBACK_Y).
  - Otherwise go back to REQ.
  - The fallback is committed without an occupancy check.
- **COMMIT:** load `apple_X`/`apple_Y`, set `apple_valid`=1, go to SHOW.
- **Boundary conditions:**
  - `eat` outside SHOW is ignored and not counted.
  - `chk_ack` outside CHECK is ignored.
  - `chk_ack` and `eat` in the same cycle: `eat` is ignored.
  - There is no checker timeout; CHECK waits indefinitely.
  - `rst_n` low mid-respawn aborts immediately to reset values. No `update` or `chk_req` is emitted during reset.

## Timing
- eat → `apple_valid`=0: 1 cycle.
- eat → `update` pulse: 2 cycles (SHOW→REQ, REQ drives).
- `update` → sample edge: SETTLE+1 cycles.
- SAMPLE → `chk_req` high: 1 cycle.
- `chk_ack` (miss) → `apple_valid`=1 with the new position: 2 cycles (CHECK→COMMIT→SHOW output).
- Minimum respawn with a zero-wait checker: SETTLE+6 cycles from `eat` to `apple_valid`.
- One `update` per try, so a respawn issues at most MAX_TRIES `update` pulses.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → `apple_X`=70, `apple_Y`=90, `apple_valid`=1, `eaten`=0, `update`=0, `chk_req`=0.
- **Single respawn:** `eat` pulse, `rand_X`=130, `rand_Y`=110 at sample, checker acks miss after 3 cycles → exactly one `update`; `chk_X`/`chk_Y`=130/110 stable while `chk_req`; apple becomes (130,110); `eaten`=1.
- **Hit retry:** checker hits twice then misses, generator giving Y=110,130,150 → 3 `update` pulses; apple Y=150.
- **Exhaustion:** checker always hits → 8 `update` pulses; apple becomes (40,40); `apple_valid`=1; FSM in SHOW.
- **Range and ignore:** candidate X=600 counts as a failed try with no `chk_req` for it. `eat` pulses while `busy`=1 do not change `eaten`. 256 accepted eats leave `eaten`=255.
- **Reset mid-CHECK:** drop `rst_n` while `chk_req`=1 → `chk_req`=0 asynchronously; reset values restored.
